// File: rtl/piso.sv
// piso: parallel-in serial-out converter, one wide word in, DEPTH narrow beats out.
// The next word may load on the same edge the last beat of the current word leaves.
module piso #(
   parameter int SERIAL_WIDTH = 8,
   parameter int DEPTH = 5,
   parameter bit MSB_FIRST = 1'b1,
   localparam int PARALLEL_WIDTH = SERIAL_WIDTH * DEPTH
) (
   input  logic                      clk_i,
   input  logic                      arst_n,
   input  logic [PARALLEL_WIDTH-1:0] data_in,
   input  logic                      data_in_valid,
   output logic                      data_in_ready,
   output logic [SERIAL_WIDTH-1:0]   data_out,
   output logic                      data_out_valid,
   input  logic                      data_out_ready,
   output logic                      data_out_last
);
   localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t                    r_state, w_state_nxt;
   logic [PARALLEL_WIDTH-1:0] r_buf, w_buf_nxt;
   logic [CW-1:0]             r_cnt, w_cnt_nxt;
   logic                      w_in_hs, w_out_hs, w_last;
   always_ff @(posedge clk_i or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= IDLE;
         r_buf   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_buf   <= w_buf_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end
   // A load on the final beat takes priority over returning to IDLE.
   always_comb begin
      w_last      = (r_state == SHIFT) && (r_cnt == CW'(DEPTH - 1));
      w_in_hs     = data_in_valid & ((r_state == IDLE) | (data_out_ready & w_last));
      w_out_hs    = (r_state == SHIFT) & data_out_ready;
      w_state_nxt = w_in_hs ? SHIFT : (w_out_hs & w_last) ? IDLE : r_state;
      w_buf_nxt   = w_in_hs ? data_in : r_buf;
      w_cnt_nxt   = w_in_hs ? '0 : !w_out_hs ? r_cnt : w_last ? '0 : r_cnt + 1'b1;
   end
   always_comb begin
      data_out_valid = (r_state == SHIFT);
      data_out_last  = w_last;
      data_in_ready  = (r_state == IDLE) | (data_out_ready & w_last);
      data_out       = MSB_FIRST ? r_buf[PARALLEL_WIDTH-1-int'(r_cnt)*SERIAL_WIDTH -: SERIAL_WIDTH]
                                 : r_buf[int'(r_cnt)*SERIAL_WIDTH +: SERIAL_WIDTH];
   end
endmodule

// File: doc/piso.md
Name: piso

Overview:
- Parallel-in serial-out converter; the transmit-side counterpart of the team's serial-in parallel-out block.
- Accepts one PARALLEL_WIDTH word on a valid/ready input channel.
- Emits it as DEPTH consecutive SERIAL_WIDTH beats on a valid/ready output channel and flags the final beat.
- Sits between wide datapath producers and narrow links or serial consumers; supports back-to-back words with no idle cycle.

Parameters:
- SERIAL_WIDTH, 8, width of one output beat in bits.
- DEPTH, 5, beats per parallel word; legal range ≥1.
- MSB_FIRST, 1, 1: first beat is data_in[PARALLEL_WIDTH-1 -: SERIAL_WIDTH]; 0: first beat is data_in[SERIAL_WIDTH-1:0].
- PARALLEL_WIDTH, SERIAL_WIDTH*DEPTH, localparam, input word width.

Ports:
- clk_i  input  1  clock, rising edge.
- arst_n  input  1  reset, asynchronous, active-low.
- data_in  input  PARALLEL_WIDTH  parallel word.
- data_in_valid  input  1  data_in is valid.
- data_in_ready  output  1  block accepts data_in this cycle.
- data_out  output  SERIAL_WIDTH  current serial beat.
- data_out_valid  output  1  data_out is valid.
- data_out_ready  input  1  downstream accepts data_out this cycle.
- data_out_last  output  1  current beat is the final beat of its word.

Behaviour:
- Reset is asynchronous on the falling edge of arst_n and released synchronously to clk_i.
- State: word buffer (PARALLEL_WIDTH), beat counter cnt (0..DEPTH-1, width max(1,$clog2(DEPTH))), busy flag. Two states: IDLE (busy=0) and SHIFT (busy=1).
- Reset values: buffer=0, cnt=0, busy=0. Hence data_out_valid=0, data_out_last=0, data_out=0, data_in_ready=1.
- data_out_valid = busy.
- data_out_last = busy & (cnt==DEPTH-1).
- data_out = beat cnt of buffer, combinational mux from registers:
  - MSB_FIRST=1: beat k = buffer[PARALLEL_WIDTH-1-k*SERIAL_WIDTH -: SERIAL_WIDTH].
  - MSB_FIRST=0: beat k = buffer[k*SERIAL_WIDTH +: SERIAL_WIDTH].
- data_in_ready = ~busy | (data_out_ready & data_out_last). This allows a new word to load on the same edge the last beat leaves.
- Input handshake: data_in_valid & data_in_ready. On that edge, buffer <= data_in, cnt <= 0, busy <= 1.
- Output handshake: data_out_valid & data_out_ready.
  - Not last beat: cnt <= cnt+1.
  - Last beat without a simultaneous input handshake: cnt <= 0, busy <= 0.
  - Last beat with a simultaneous input handshake: the input load wins; stays busy with the new word at cnt=0.
- Latency: a word accepted at edge N presents beat 0 in the cycle after edge N.
- Throughput: one beat per cycle while data_out_ready=1. Sustained words take DEPTH cycles each with no bubble.
- Backpressure: while data_out_valid & ~data_out_ready, data_out, data_out_last and cnt hold stable.
- Buffer is never modified mid-word. data_in changes during SHIFT have no effect.
- IDLE: buffer and cnt hold. data_out shows beat 0 of the previous word (0 after reset) and is don't-care to consumers.
- DEPTH=1: every valid beat has data_out_last=1. The block acts as a one-entry register slice with full throughput.
- Reset mid-word: the partial word is dropped. data_out_valid falls asynchronously. The first word after reset starts at beat 0.
- data_in_valid is not required to be held. data_in_ready does not depend combinationally on data_in_valid.

Test Plan:
- MSB_FIRST=1, SW=8, DEPTH=5, data_out_ready=1, single word 40'h1122334455 -> beats 11,22,33,44,55 on five consecutive cycles starting one cycle after acceptance; last=1 only on 55; then valid=0 and ready=1.
- MSB_FIRST=0, same word -> beats 55,44,33,22,11; last on 11.
- MSB_FIRST=1, data_out_ready low for 3 cycles while beat 22 is presented -> data_out=22 and last=0 held for 4 cycles; data_in_ready=0 throughout; remaining beats follow unchanged.
- Back-to-back: words 40'h1122334455 then 40'hAABBCCDDEE, with data_in_valid held and ready=1 -> second word accepted on the cycle beat 55 is taken; 10 beats 11..55,AA..EE in 10 consecutive cycles; last on 55 and EE.
- Reset asserted after 2 beats of 40'h1122334455 -> valid=0 immediately and ready=1 after release; next word 40'h0102030405 emits 01..05 from beat 0.
- DEPTH=1, SW=8, words 8'hA5, 8'h5A with ready=1 -> outputs A5 then 5A on consecutive cycles, last=1 on both, data_in_ready stays 1.
